// File: rtl/mux_arb_pkg.sv
// Shared definitions for the N-to-1 streaming arbiter mux: mode encodings and
// the priority search helper used by the grant logic.
package mux_arb_pkg;

    localparam logic [1:0] MODE_SEL  = 2'd0;
    localparam logic [1:0] MODE_PRIO = 2'd1;
    localparam logic [1:0] MODE_RR   = 2'd2;
    localparam logic [1:0] MODE_OFF  = 2'd3;

    localparam int unsigned MAX_N = 16;
    localparam int unsigned IDXW  = 4;

    // Returns {found, index} of the lowest set bit of v.
    function automatic logic [IDXW:0] first_set(input logic [MAX_N-1:0] v);
        logic [IDXW:0] r;
        r = '0;
        for (int i = MAX_N - 1; i >= 0; i--) begin
            if (v[i]) r = {1'b1, IDXW'(i)};
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational rotating-priority grant: first requester at or after ptr_i,
// wrapping at N-1. Driving ptr_i to zero gives plain lowest-index priority.
module rr_grant
    import mux_arb_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter int unsigned SELW = $clog2(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [SELW-1:0] ptr_i,
    output logic            gnt_valid_o,
    output logic [SELW-1:0] gnt_idx_o
);

    logic [2*N-1:0]   dbl;
    logic [2*N-1:0]   rot;
    logic [MAX_N-1:0] win;
    logic [IDXW:0]    hit;
    logic [SELW:0]    sum;

    // Rotate so ptr_i lands at bit 0, search, then rotate the index back modulo N.
    always_comb begin
        dbl          = {req_i, req_i};
        rot          = dbl >> ptr_i;
        win          = '0;
        win[N-1:0]   = rot[N-1:0];
        hit          = first_set(win);
        sum          = (SELW+1)'(ptr_i) + (SELW+1)'(hit[IDXW-1:0]);
        if (sum >= (SELW+1)'(N)) sum = sum - (SELW+1)'(N);
        gnt_valid_o  = hit[IDXW];
        gnt_idx_o    = sum[SELW-1:0];
    end

endmodule

// File: rtl/mux_n1_arb.sv
// N-to-1 valid/ready channel mux with selectable arbitration (external select,
// fixed priority, round-robin) feeding a single registered output stage.
module mux_n1_arb
    import mux_arb_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SELW  = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         mode_i,
    input  logic [SELW-1:0]    sel_i,
    input  logic [N-1:0]       in_valid_i,
    input  logic [N*WIDTH-1:0] in_data_i,
    output logic [N-1:0]       in_ready_o,
    output logic               out_valid_o,
    output logic [WIDTH-1:0]   out_data_o,
    output logic [SELW-1:0]    out_ch_o,
    input  logic               out_ready_i
);

    localparam int unsigned NPOW = 2 ** SELW;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SELW-1:0]  out_ch_q,    out_ch_d;
    logic [SELW-1:0]  ptr_q,       ptr_d;

    logic [NPOW-1:0]  valid_ext;
    logic [WIDTH-1:0] ch_data [NPOW];
    logic [SELW-1:0]  arb_ptr;
    logic             arb_valid;
    logic [SELW-1:0]  arb_idx;
    logic             gnt_valid;
    logic [SELW-1:0]  gnt_idx;
    logic             load_c;
    logic             xfer_c;
    logic [NPOW-1:0]  rdy_ext;

    // Channel views padded to 2^SELW so out-of-range selects read as idle.
    always_comb begin
        valid_ext = NPOW'(in_valid_i);
        for (int k = 0; k < int'(NPOW); k++) begin
            ch_data[k] = '0;
            if (k < int'(N)) ch_data[k] = in_data_i[k*WIDTH +: WIDTH];
        end
    end

    assign arb_ptr = (mode_i == MODE_PRIO) ? '0 : ptr_q;

    rr_grant #(.N(N), .SELW(SELW)) u_grant (
        .req_i       (in_valid_i),
        .ptr_i       (arb_ptr),
        .gnt_valid_o (arb_valid),
        .gnt_idx_o   (arb_idx)
    );

    // Mode mux: at most one granted channel per cycle.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        case (mode_i)
            MODE_SEL: begin
                gnt_valid = (32'(sel_i) < N) && valid_ext[sel_i];
                gnt_idx   = sel_i;
            end
            MODE_PRIO, MODE_RR: begin
                gnt_valid = arb_valid;
                gnt_idx   = arb_idx;
            end
            default: begin
                gnt_valid = 1'b0;
                gnt_idx   = '0;
            end
        endcase
    end

    // Ready is a pure function of the grant and output-stage occupancy; reset masks it.
    always_comb begin
        load_c  = !out_valid_q || out_ready_i;
        xfer_c  = gnt_valid && load_c && !rst;
        rdy_ext = '0;
        if (xfer_c) rdy_ext[gnt_idx] = 1'b1;
        in_ready_o = rdy_ext[N-1:0];
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
        if (xfer_c) begin
            out_valid_d = 1'b1;
            out_data_d  = ch_data[gnt_idx];
            out_ch_d    = gnt_idx;
            if (mode_i == MODE_RR) begin
                ptr_d = (gnt_idx == SELW'(N - 1)) ? '0 : gnt_idx + SELW'(1);
            end
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_ch_o    = out_ch_q;

endmodule

// File: tb/tb_mux_n1_arb.sv
// Directed, table-driven check of mux_n1_arb (N=4, WIDTH=8) with hand-computed
// expectations, plus backpressure and mid-stream reset sequences.
module tb_mux_n1_arb;

    localparam int unsigned N     = 4;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned SELW  = 2;

    localparam logic [31:0] D_STD = 32'h1312_1110;
    localparam logic [31:0] D_A5  = 32'h13A5_1110;

    logic               clk = 1'b0;
    logic               rst;
    logic [1:0]         mode;
    logic [SELW-1:0]    sel;
    logic [N-1:0]       in_valid;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_ch;
    logic               out_ready;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mux_n1_arb #(.N(N), .WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .mode_i      (mode),
        .sel_i       (sel),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .in_ready_o  (in_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_ch_o    (out_ch),
        .out_ready_i (out_ready)
    );

    typedef struct {
        string       name;
        logic        rst;
        logic [1:0]  mode;
        logic [1:0]  sel;
        logic [3:0]  valid;
        logic        oready;
        logic [31:0] data;
        logic [3:0]  rdy;
        logic        ov;
        logic [7:0]  od;
        logic [1:0]  och;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic r, logic [1:0] m, logic [1:0] s,
                                logic [3:0] v, logic ordy, logic [31:0] d,
                                logic [3:0] rdy, logic ov, logic [7:0] od, logic [1:0] och);
        vec_t t;
        t.name = name; t.rst = r; t.mode = m; t.sel = s; t.valid = v; t.oready = ordy;
        t.data = d; t.rdy = rdy; t.ov = ov; t.od = od; t.och = och;
        return t;
    endfunction

    task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", what, act, exp);
        end
    endtask

    // Drive one cycle: check the combinational ready, then the registered outputs after the edge.
    task automatic step(input vec_t v);
        rst       = v.rst;
        mode      = v.mode;
        sel       = v.sel;
        in_valid  = v.valid;
        out_ready = v.oready;
        in_data   = v.data;
        #1;
        check({v.name, ".in_ready"}, 32'(in_ready), 32'(v.rdy));
        @(posedge clk);
        #1;
        check({v.name, ".out_valid"}, 32'(out_valid), 32'(v.ov));
        check({v.name, ".out_data"},  32'(out_data),  32'(v.od));
        check({v.name, ".out_ch"},    32'(out_ch),    32'(v.och));
    endtask

    initial begin
        //                 name      rst mode sel valid    ordy data   rdy      ov  od     och
        vecs.push_back(mk("rst0",    1, 2'd2, 0, 4'b1111, 1, D_STD, 4'b0000, 0, 8'h00, 0));
        vecs.push_back(mk("rst1",    1, 2'd2, 0, 4'b1111, 1, D_STD, 4'b0000, 0, 8'h00, 0));
        vecs.push_back(mk("sel2",    0, 2'd0, 2, 4'b0100, 1, D_A5,  4'b0100, 1, 8'hA5, 2));
        vecs.push_back(mk("sel3idle",0, 2'd0, 3, 4'b0100, 1, D_A5,  4'b0000, 0, 8'hA5, 2));
        vecs.push_back(mk("sel2bp",  0, 2'd0, 2, 4'b0100, 0, D_A5,  4'b0100, 1, 8'hA5, 2));
        vecs.push_back(mk("sel2hold",0, 2'd0, 2, 4'b0100, 0, D_STD, 4'b0000, 1, 8'hA5, 2));
        vecs.push_back(mk("off",     0, 2'd3, 0, 4'b1111, 1, D_STD, 4'b0000, 0, 8'hA5, 2));
        vecs.push_back(mk("prio_a",  0, 2'd1, 0, 4'b1110, 1, D_STD, 4'b0010, 1, 8'h11, 1));
        vecs.push_back(mk("prio_b",  0, 2'd1, 0, 4'b1110, 1, D_STD, 4'b0010, 1, 8'h11, 1));
        vecs.push_back(mk("prio_c",  0, 2'd1, 0, 4'b1110, 1, D_STD, 4'b0010, 1, 8'h11, 1));
        vecs.push_back(mk("prio_0",  0, 2'd1, 0, 4'b1111, 1, D_STD, 4'b0001, 1, 8'h10, 0));
        vecs.push_back(mk("rr0",     0, 2'd2, 0, 4'b1111, 1, D_STD, 4'b0001, 1, 8'h10, 0));
        vecs.push_back(mk("rr1",     0, 2'd2, 0, 4'b1111, 1, D_STD, 4'b0010, 1, 8'h11, 1));
        vecs.push_back(mk("rr2",     0, 2'd2, 0, 4'b1111, 1, D_STD, 4'b0100, 1, 8'h12, 2));
        vecs.push_back(mk("rr3",     0, 2'd2, 0, 4'b1111, 1, D_STD, 4'b1000, 1, 8'h13, 3));
        vecs.push_back(mk("rrwrap",  0, 2'd2, 0, 4'b1111, 1, D_STD, 4'b0001, 1, 8'h10, 0));
        vecs.push_back(mk("rrskip",  0, 2'd2, 0, 4'b1001, 1, D_STD, 4'b1000, 1, 8'h13, 3));
        vecs.push_back(mk("rrfrom0", 0, 2'd2, 0, 4'b0110, 1, D_STD, 4'b0010, 1, 8'h11, 1));
        vecs.push_back(mk("prio_mid",0, 2'd1, 0, 4'b1111, 1, D_STD, 4'b0001, 1, 8'h10, 0));
        vecs.push_back(mk("rrkeep",  0, 2'd2, 0, 4'b1111, 1, D_STD, 4'b0100, 1, 8'h12, 2));
        vecs.push_back(mk("rridle",  0, 2'd2, 0, 4'b0000, 1, D_STD, 4'b0000, 0, 8'h12, 2));
        vecs.push_back(mk("rrafter", 0, 2'd2, 0, 4'b1111, 1, D_STD, 4'b1000, 1, 8'h13, 3));

        foreach (vecs[i]) step(vecs[i]);

        // Backpressure: output held, no ready, pointer frozen at 0.
        for (int i = 0; i < 3; i++)
            step(mk("bp_hold", 0, 2'd2, 0, 4'b1111, 0, D_STD, 4'b0000, 1, 8'h13, 3));
        step(mk("bp_rel",   0, 2'd2, 0, 4'b1111, 1, D_STD, 4'b0001, 1, 8'h10, 0));
        step(mk("bp_next",  0, 2'd2, 0, 4'b1111, 1, D_STD, 4'b0010, 1, 8'h11, 1));

        // Reset with ptr=2 and a word held: word dropped, ptr back to 0.
        step(mk("mid_rst",  1, 2'd2, 0, 4'b1111, 1, D_STD, 4'b0000, 0, 8'h00, 0));
        step(mk("post_rst", 0, 2'd2, 0, 4'b1111, 1, D_STD, 4'b0001, 1, 8'h10, 0));
        step(mk("post_rst2",0, 2'd2, 0, 4'b1111, 1, D_STD, 4'b0010, 1, 8'h11, 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
